// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the master bit controller and the target.
// Commands, FSM encodings and the ACK/NACK bus levels.
package i2c_pkg;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [2:0] {
    CMD_NOP,
    CMD_START,
    CMD_STOP,
    CMD_WRITE,
    CMD_READ
  } i2c_cmd_e;

  // One-hot phases of the master bit controller.
  typedef enum logic [4:0] {
    BC_IDLE = 5'b00001,
    BC_A    = 5'b00010,
    BC_B    = 5'b00100,
    BC_C    = 5'b01000,
    BC_D    = 5'b10000
  } bc_state_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_WR_DATA,
    S_WR_ACK,
    S_RD_LOAD,
    S_RD_DATA,
    S_RD_ACK
  } slv_state_e;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// SCL/SDA conditioning: 2-flop sync, 3-tap majority, edge and
// START/STOP detection. Pad-to-detect latency is 5 clk.
module i2c_line_filter
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_f_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [1:0] scl_sync_q, sda_sync_q;
  logic [2:0] scl_tap_q, sda_tap_q;
  logic       scl_s_q, scl_d_q;
  logic       sda_s_q, sda_d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_tap_q  <= 3'b111;
      sda_tap_q  <= 3'b111;
      scl_s_q    <= 1'b1;
      scl_d_q    <= 1'b1;
      sda_s_q    <= 1'b1;
      sda_d_q    <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_tap_q  <= {scl_tap_q[1:0], scl_sync_q[1]};
      sda_tap_q  <= {sda_tap_q[1:0], sda_sync_q[1]};
      scl_s_q    <= maj3(scl_tap_q);
      sda_s_q    <= maj3(sda_tap_q);
      scl_d_q    <= scl_s_q;
      sda_d_q    <= sda_s_q;
    end
  end

  assign sda_f_o    = sda_s_q;
  assign scl_rise_o = scl_s_q & ~scl_d_q;
  assign scl_fall_o = ~scl_s_q & scl_d_q;
  assign start_o    = ~sda_s_q & sda_d_q & scl_s_q;
  assign stop_o     = sda_s_q & ~sda_d_q & scl_s_q;

endmodule

// File: rtl/i2c_slave_byte_ctrl.sv
// I2C target byte controller: address match, write receive,
// read transmit with SCL stretching, ACK generation.
module i2c_slave_byte_ctrl
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       scl_i,
  output logic       scl_o,
  output logic       scl_oen,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_oen,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       start_det,
  output logic       stop_det,
  output logic       rd_nack
);

  logic sda_s, rise, fall, start, stop;

  i2c_line_filter u_filt (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda_f_o   (sda_s),
    .scl_rise_o(rise),
    .scl_fall_o(fall),
    .start_o   (start),
    .stop_o    (stop)
  );

  slv_state_e state_q;
  logic [2:0] cnt_q;
  logic [6:0] sr_q;
  logic       rw_q, ack_ok_q;
  logic       scl_oen_q, sda_oen_q;
  logic [7:0] rx_data_q;
  logic       rx_valid_q, tx_ready_q, busy_q;
  logic       start_det_q, stop_det_q, rd_nack_q;

  // In the ACK states, sda_oen_q tells which fall we are at:
  // released means the first fall (start driving), low means the second.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sr_q        <= '0;
      rw_q        <= 1'b0;
      ack_ok_q    <= 1'b0;
      scl_oen_q   <= 1'b1;
      sda_oen_q   <= 1'b1;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      start_det_q <= 1'b0;
      stop_det_q  <= 1'b0;
      rd_nack_q   <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      tx_ready_q  <= 1'b0;
      start_det_q <= 1'b0;
      stop_det_q  <= 1'b0;
      rd_nack_q   <= 1'b0;
      if (!ena) begin
        state_q   <= S_IDLE;
        cnt_q     <= '0;
        ack_ok_q  <= 1'b0;
        scl_oen_q <= 1'b1;
        sda_oen_q <= 1'b1;
        rx_data_q <= '0;
        busy_q    <= 1'b0;
      end else if (stop) begin
        state_q    <= S_IDLE;
        scl_oen_q  <= 1'b1;
        sda_oen_q  <= 1'b1;
        busy_q     <= 1'b0;
        stop_det_q <= 1'b1;
      end else if (start) begin
        state_q     <= S_ADDR;
        cnt_q       <= '0;
        scl_oen_q   <= 1'b1;
        sda_oen_q   <= 1'b1;
        start_det_q <= 1'b1;
      end else begin
        unique case (state_q)
          S_IDLE: ;
          S_ADDR: if (rise) begin
            sr_q  <= {sr_q[5:0], sda_s};
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (sr_q == SLAVE_ADDR) begin
                rw_q    <= sda_s;
                state_q <= S_ADDR_ACK;
              end else begin
                state_q <= S_IDLE;
              end
            end
          end
          S_ADDR_ACK: if (fall) begin
            if (sda_oen_q) begin
              sda_oen_q <= I2C_ACK;
              busy_q    <= 1'b1;
            end else begin
              sda_oen_q <= 1'b1;
              state_q   <= rw_q ? S_RD_LOAD : S_WR_DATA;
            end
          end
          S_WR_DATA: if (rise) begin
            sr_q  <= {sr_q[5:0], sda_s};
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              rx_data_q  <= {sr_q, sda_s};
              rx_valid_q <= 1'b1;
              state_q    <= S_WR_ACK;
            end
          end
          S_WR_ACK: if (fall) begin
            if (sda_oen_q) begin
              sda_oen_q <= I2C_ACK;
            end else begin
              sda_oen_q <= 1'b1;
              state_q   <= S_WR_DATA;
            end
          end
          S_RD_LOAD: begin
            if (tx_valid) begin
              sr_q       <= tx_data[6:0];
              sda_oen_q  <= tx_data[7];
              tx_ready_q <= 1'b1;
              cnt_q      <= '0;
              state_q    <= S_RD_DATA;
            end else begin
              scl_oen_q  <= 1'b0;
            end
          end
          S_RD_DATA: begin
            // Releasing SCL one clk after bit7 gives SDA setup time.
            if (!scl_oen_q) scl_oen_q <= 1'b1;
            if (fall) begin
              if (cnt_q == 3'd7) begin
                sda_oen_q <= 1'b1;
                cnt_q     <= '0;
                ack_ok_q  <= 1'b0;
                state_q   <= S_RD_ACK;
              end else begin
                sda_oen_q <= sr_q[6];
                sr_q      <= {sr_q[5:0], 1'b0};
                cnt_q     <= cnt_q + 3'd1;
              end
            end
          end
          S_RD_ACK: begin
            if (rise) begin
              if (sda_s == I2C_NACK) begin
                rd_nack_q <= 1'b1;
                state_q   <= S_IDLE;
              end else begin
                ack_ok_q  <= 1'b1;
              end
            end else if (fall && ack_ok_q) begin
              ack_ok_q <= 1'b0;
              state_q  <= S_RD_LOAD;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign scl_o     = 1'b0;
  assign sda_o     = 1'b0;
  assign scl_oen   = scl_oen_q;
  assign sda_oen   = sda_oen_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign tx_ready  = tx_ready_q;
  assign busy      = busy_q;
  assign start_det = start_det_q;
  assign stop_det  = stop_det_q;
  assign rd_nack   = rd_nack_q;

endmodule

// File: tb/tb_i2c_slave_byte_ctrl.sv
// Bench for i2c_slave_byte_ctrl: bus master model on open-drain
// lines, scoreboard queues for received and transmitted bytes.
module tb_i2c_slave_byte_ctrl;

  localparam int Q = 16;

  logic       clk = 1'b0;
  logic       rst, ena, scl_m, sda_m, tx_valid;
  logic [7:0] tx_data;
  logic       scl_o, scl_oen, sda_o, sda_oen;
  logic [7:0] rx_data;
  logic       rx_valid, tx_ready, busy;
  logic       start_det, stop_det, rd_nack;
  logic       scl_pad, sda_pad;

  assign scl_pad = scl_m & (scl_oen ? 1'b1 : scl_o);
  assign sda_pad = sda_m & (sda_oen ? 1'b1 : sda_o);

  i2c_slave_byte_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .scl_i    (scl_pad),
    .scl_o    (scl_o),
    .scl_oen  (scl_oen),
    .sda_i    (sda_pad),
    .sda_o    (sda_o),
    .sda_oen  (sda_oen),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .start_det(start_det),
    .stop_det (stop_det),
    .rd_nack  (rd_nack)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int to_cnt = 0;
  int n_start, n_stop, n_rxv, n_txr, n_nack;
  logic saw_sda_low, saw_busy;
  logic [7:0] exp_rx[$];
  logic [7:0] got_rx[$];
  logic [7:0] exp_tx[$];
  logic [7:0] tx_src[$];

  initial forever begin
    @(negedge clk);
    if (rx_valid) begin
      got_rx.push_back(rx_data);
      n_rxv++;
    end
    if (tx_ready)  n_txr++;
    if (start_det) n_start++;
    if (stop_det)  n_stop++;
    if (rd_nack)   n_nack++;
    if (!sda_oen)  saw_sda_low = 1'b1;
    if (busy)      saw_busy = 1'b1;
  end

  initial forever begin
    @(negedge clk);
    if (tx_ready) begin
      if (tx_src.size() > 0) tx_data = tx_src.pop_front();
      else tx_valid = 1'b0;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr();
    n_start = 0; n_stop = 0; n_rxv = 0;
    n_txr = 0; n_nack = 0;
    saw_sda_low = 1'b0; saw_busy = 1'b0;
    got_rx.delete();
  endtask

  task automatic send_bit(input logic b, output logic s);
    int i;
    sda_m = b;
    tick(Q);
    scl_m = 1'b1;
    i = 0;
    while (scl_pad !== 1'b1 && i < 4000) begin
      tick(1);
      i++;
    end
    if (scl_pad !== 1'b1) to_cnt++;
    tick(Q);
    s = sda_pad;
    tick(Q);
    scl_m = 1'b0;
    tick(4);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int k = 7; k >= 0; k--) send_bit(b[k], s);
    send_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    logic s;
    b = '0;
    for (int k = 0; k < 8; k++) begin
      send_bit(1'b1, s);
      b = {b[6:0], s};
    end
    send_bit(mack, s);
  endtask

  task automatic do_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(4);
  endtask

  task automatic do_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    total_cnt++;
    if (scl_oen !== 1'b1) $display("FAIL rst_scl_oen got=%b exp=1", scl_oen);
    else pass_cnt++;
    total_cnt++;
    if (sda_oen !== 1'b1) $display("FAIL rst_sda_oen got=%b exp=1", sda_oen);
    else pass_cnt++;
    total_cnt++;
    if (rx_data !== 8'h00) $display("FAIL rst_rx_data got=%h exp=00", rx_data);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy);
    else pass_cnt++;
    total_cnt++;
    if ({rx_valid, tx_ready, start_det, stop_det, rd_nack} !== 5'b0)
      $display("FAIL rst_pulses got=%b exp=00000",
               {rx_valid, tx_ready, start_det, stop_det, rd_nack});
    else pass_cnt++;
    rst = 1'b0;
    tick(20);
  endtask

  task automatic test_write();
    logic a;
    logic [7:0] e, g;
    clr();
    do_start();
    write_byte(8'hA0, a);
    total_cnt++;
    if (a !== 1'b0) $display("FAIL wr_addr_ack got=%b exp=0", a);
    else pass_cnt++;
    exp_rx.push_back(8'hA5);
    write_byte(8'hA5, a);
    total_cnt++;
    if (a !== 1'b0) $display("FAIL wr_data_ack got=%b exp=0", a);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL wr_busy_mid got=%b exp=1", busy);
    else pass_cnt++;
    do_stop();
    tick(20);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL wr_busy_end got=%b exp=0", busy);
    else pass_cnt++;
    while (exp_rx.size() > 0) begin
      e = exp_rx.pop_front();
      g = (got_rx.size() > 0) ? got_rx.pop_front() : 8'hxx;
      total_cnt++;
      if (g !== e) $display("FAIL wr_rx_data got=%h exp=%h", g, e);
      else pass_cnt++;
    end
    total_cnt++;
    if (n_rxv !== 1) $display("FAIL wr_rx_pulses got=%0d exp=1", n_rxv);
    else pass_cnt++;
    total_cnt++;
    if (n_start !== 1 || n_stop !== 1)
      $display("FAIL wr_start_stop got=%0d/%0d exp=1/1", n_start, n_stop);
    else pass_cnt++;
  endtask

  task automatic test_addr_mismatch();
    logic a;
    clr();
    do_start();
    write_byte(8'h62, a);
    do_stop();
    tick(20);
    total_cnt++;
    if (a !== 1'b1) $display("FAIL nm_ack got=%b exp=1", a);
    else pass_cnt++;
    total_cnt++;
    if (saw_sda_low !== 1'b0) $display("FAIL nm_sda_driven got=%b exp=0", saw_sda_low);
    else pass_cnt++;
    total_cnt++;
    if (saw_busy !== 1'b0) $display("FAIL nm_busy got=%b exp=0", saw_busy);
    else pass_cnt++;
    total_cnt++;
    if (n_rxv !== 0) $display("FAIL nm_rx_valid got=%0d exp=0", n_rxv);
    else pass_cnt++;
  endtask

  task automatic test_read();
    logic a;
    logic [7:0] rb, e;
    clr();
    tx_data = 8'h3C;
    tx_valid = 1'b1;
    tx_src.push_back(8'hC3);
    exp_tx.push_back(8'h3C);
    exp_tx.push_back(8'hC3);
    do_start();
    write_byte(8'hA1, a);
    total_cnt++;
    if (a !== 1'b0) $display("FAIL rd_addr_ack got=%b exp=0", a);
    else pass_cnt++;
    for (int k = 0; k < 2; k++) begin
      read_byte(k == 1, rb);
      e = exp_tx.pop_front();
      total_cnt++;
      if (rb !== e) $display("FAIL rd_byte%0d got=%h exp=%h", k, rb, e);
      else pass_cnt++;
    end
    do_stop();
    tick(20);
    total_cnt++;
    if (n_txr !== 2) $display("FAIL rd_tx_ready got=%0d exp=2", n_txr);
    else pass_cnt++;
    total_cnt++;
    if (n_nack !== 1) $display("FAIL rd_nack got=%0d exp=1", n_nack);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL rd_busy_end got=%b exp=0", busy);
    else pass_cnt++;
  endtask

  task automatic test_stretch();
    logic a, got_str, held, rel_ok, rel_sda;
    logic [7:0] rb, e;
    int i;
    clr();
    tx_valid = 1'b0;
    do_start();
    write_byte(8'hA1, a);
    fork
      read_byte(1'b1, rb);
      begin
        i = 0;
        while (scl_oen !== 1'b0 && i < 2000) begin
          tick(1);
          i++;
        end
        got_str = (scl_oen === 1'b0);
        held = 1'b1;
        for (int j = 0; j < 200; j++) begin
          tick(1);
          if (scl_oen !== 1'b0) held = 1'b0;
        end
        tx_data = 8'h5A;
        tx_valid = 1'b1;
        exp_tx.push_back(8'h5A);
        i = 0;
        while (scl_oen !== 1'b1 && i < 50) begin
          tick(1);
          i++;
        end
        rel_ok = scl_oen;
        rel_sda = sda_oen;
      end
    join
    total_cnt++;
    if (got_str !== 1'b1) $display("FAIL st_stretch got=%b exp=1", got_str);
    else pass_cnt++;
    total_cnt++;
    if (held !== 1'b1) $display("FAIL st_held got=%b exp=1", held);
    else pass_cnt++;
    total_cnt++;
    if ({rel_ok, rel_sda} !== 2'b10)
      $display("FAIL st_release got=%b exp=10", {rel_ok, rel_sda});
    else pass_cnt++;
    e = exp_tx.pop_front();
    total_cnt++;
    if (rb !== e) $display("FAIL st_byte got=%h exp=%h", rb, e);
    else pass_cnt++;
    do_stop();
    tick(20);
  endtask

  task automatic test_rstart();
    logic a, s;
    logic [7:0] rb, e;
    clr();
    tx_data = 8'h96;
    tx_valid = 1'b1;
    exp_tx.push_back(8'h96);
    do_start();
    write_byte(8'hA0, a);
    send_bit(1'b1, s);
    send_bit(1'b0, s);
    do_start();
    write_byte(8'hA1, a);
    total_cnt++;
    if (a !== 1'b0) $display("FAIL rs_addr_ack got=%b exp=0", a);
    else pass_cnt++;
    read_byte(1'b1, rb);
    e = exp_tx.pop_front();
    total_cnt++;
    if (rb !== e) $display("FAIL rs_byte got=%h exp=%h", rb, e);
    else pass_cnt++;
    do_stop();
    tick(20);
    total_cnt++;
    if (n_rxv !== 0) $display("FAIL rs_rx_valid got=%0d exp=0", n_rxv);
    else pass_cnt++;
    total_cnt++;
    if (n_start !== 2) $display("FAIL rs_starts got=%0d exp=2", n_start);
    else pass_cnt++;
  endtask

  task automatic test_rst_mid();
    logic a, s;
    logic [7:0] d;
    int i;
    clr();
    d = 8'h33;
    do_start();
    write_byte(8'hA0, a);
    for (int k = 7; k >= 0; k--) send_bit(d[k], s);
    i = 0;
    while (sda_oen !== 1'b0 && i < 100) begin
      tick(1);
      i++;
    end
    total_cnt++;
    if (sda_oen !== 1'b0) $display("FAIL rm_ack_drive got=%b exp=0", sda_oen);
    else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({sda_oen, scl_oen} !== 2'b11)
      $display("FAIL rm_release got=%b exp=11", {sda_oen, scl_oen});
    else pass_cnt++;
    total_cnt++;
    if ({busy, rx_data} !== 9'h000)
      $display("FAIL rm_state got=%h exp=000", {busy, rx_data});
    else pass_cnt++;
    tick(2);
    rst = 1'b0;
    tick(4);
    do_stop();
    tick(20);
  endtask

  initial begin
    ena = 1'b1;
    scl_m = 1'b1;
    sda_m = 1'b1;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    clr();
    test_reset();
    test_write();
    test_addr_mismatch();
    test_read();
    test_stretch();
    test_rstart();
    test_rst_mid();
    total_cnt++;
    if (to_cnt !== 0) $display("FAIL scl_timeouts got=%0d exp=0", to_cnt);
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
